seq_mul_add16: RTL and testbench
================================

Name: seq_mul_add16

Overview:
- Sequential arithmetic datapath that multiplies two unsigned 8-bit operands with shift-and-add, then adds the 16-bit product to a 16-bit accumulator operand.
- It provides the multiply and add stages of the neural-network MAC: a controller supplies the input sample, the weight and the running sum, and takes back the new sum.
- A start/done handshake lets the controller sequence one MAC step at a time.

Parameters:
- OP_W, 8, width of each multiplier operand.
- ACC_W, 16, width of the product, accumulator input and result; must equal 2*OP_W.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset; 0 clears all state immediately.
- start, input, 1, request a new operation; sampled only in IDLE or DONE.
- x, input, OP_W, multiplicand (unsigned).
- y, input, OP_W, multiplier (unsigned).
- acc_in, input, ACC_W, addend (running sum, unsigned).
- product, output, ACC_W, registered x*y.
- mul_done, output, 1, product is final.
- result, output, ACC_W, registered (x*y + acc_in) mod 2^ACC_W.
- carry, output, 1, carry out of the final add.
- done, output, 1, result and carry are valid.
- busy, output, 1, high in MUL or ADD.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; product, result, carry, mul_done, done, busy and the internal registers all go to 0.
  - Reset asserted mid-operation aborts the operation. No partial value may appear at the outputs.
- States: IDLE, MUL, ADD, DONE.
- IDLE or DONE with start=1 at edge E0:
  - latch x, y and acc_in into internal registers;
  - clear product, result, carry, mul_done and done;
  - bit counter = 0; go to MUL.
- MUL, edges E1..E8, one multiplier bit per edge, LSB first:
  - if the current multiplier bit is 1, add the multiplicand shifted left by the bit index into the product accumulator;
  - increment the counter.
- End of MUL: at E8 (counter reaches OP_W) product holds the full x*y, mul_done=1, go to ADD.
- ADD, edge E9:
  - result = product + latched acc_in, truncated to ACC_W;
  - carry = bit ACC_W of the sum;
  - done=1; go to DONE.
- DONE:
  - result, carry, product, mul_done and done hold until the next start or reset.
  - start=1 in DONE begins a new operation at that edge; done drops at that edge.
- Latency: done is first visible after edge E9, 9 clock edges after the edge that sampled start.
- start in MUL or ADD is ignored. Operands are taken only from the latched copies, so x, y and acc_in may change freely after E0.
- busy=1 exactly in MUL and ADD. done and mul_done are levels, not pulses.
- Arithmetic is unsigned. The product cannot overflow: max 255*255=65025. Overflow is possible only in the add, and it is reported on carry.
- x=0 or y=0 still takes the full 8 MUL cycles; there is no early termination.

Decomposition:
- Shared package: OP_W and ACC_W constants, the state enum (IDLE, MUL, ADD, DONE) and the counter width $clog2(OP_W+1).
- One natural sub-module, shift_add_mult. It holds the MUL-phase datapath: latched multiplicand, latched multiplier, product accumulator and bit counter, plus its own done flag.
- The top level holds the FSM, the add stage and the output registers.

Test Plan:
- Reset then idle: reset=0 then 1 with no start -> all outputs 0, state IDLE, busy=0.
- Basic MAC: x=5, y=2, acc_in=10, start pulse:
  - mul_done=1 with product=10 after E8;
  - done=1 with result=20, carry=0 after E9;
  - busy high for exactly 9 cycles.
- Maximum operands: x=255, y=255, acc_in=0 -> product=65025, result=65025, carry=0. Then acc_in=1000 -> result=489, carry=1.
- Zero operand: x=0, y=200, acc_in=1234 -> product=0, result=1234, done after the same 9-edge latency.
- Protocol:
  - start re-pulsed during MUL with different operands -> ignored, first result unchanged;
  - start in DONE -> done drops at that edge, new result 9 edges later;
  - changing x, y, acc_in after E0 -> no effect.
- Reset mid-MUL: reset=0 at E4 -> all outputs 0 asynchronously. After release and a new start (x=3, y=3, acc_in=0) -> result=9.

Source files
------------

// File: rtl/seq_mul_add16_pkg.sv
// Shared constants and state encoding for the sequential multiply-add MAC stage.
package seq_mul_add16_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_mul_add16_shift_add_mult.sv
// Shift-and-add multiplier: one multiplier bit per enabled cycle, LSB first.
module shift_add_mult
    import seq_mul_add16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [OP_W-1:0]  x,
    input  logic [OP_W-1:0]  y,
    output logic [ACC_W-1:0] prod,
    output logic             done,
    output logic             last
);

    logic [ACC_W-1:0] mcand_q, mcand_d;
    logic [OP_W-1:0]  mplier_q, mplier_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] partial;

    // Multiplicand moves left and multiplier moves right, so bit 0 is always the current bit.
    assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = step && !done_q && (cnt_q == CNT_W'(OP_W - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        done_d   = done_q;
        if (load) begin
            mcand_d  = {{(ACC_W - OP_W){1'b0}}, x};
            mplier_d = y;
            acc_d    = '0;
            cnt_d    = '0;
            prod_d   = '0;
            done_d   = 1'b0;
        end else if (step && !done_q) begin
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Product output only ever shows the finished value, never a partial sum.
            if (last) begin
                prod_d = partial;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
        end
    end

    assign prod = prod_q;
    assign done = done_q;

endmodule

// File: rtl/seq_mul_add16.sv
// MAC step controller: 8-cycle shift-add multiply followed by a one-cycle accumulate.
//   state  | meaning
//   S_IDLE | waiting for start after reset
//   S_MUL  | one multiplier bit per cycle (8 cycles)
//   S_ADD  | product + latched acc_in into result/carry
//   S_DONE | outputs held; start launches the next step
module seq_mul_add16
    import seq_mul_add16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  x,
    input  logic [OP_W-1:0]  y,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] product,
    output logic             mul_done,
    output logic [ACC_W-1:0] result,
    output logic             carry,
    output logic             done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_in_q, acc_in_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             mul_load, mul_step, mul_last;
    logic [ACC_W-1:0] mul_prod;
    logic [ACC_W:0]   sum;

    shift_add_mult u_mult (
        .clk   (clk),
        .rst_n (reset),
        .load  (mul_load),
        .step  (mul_step),
        .x     (x),
        .y     (y),
        .prod  (mul_prod),
        .done  (mul_done),
        .last  (mul_last)
    );

    assign sum = {1'b0, mul_prod} + {1'b0, acc_in_q};

    always_comb begin
        state_d  = state_q;
        acc_in_d = acc_in_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = done_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mul_load = 1'b1;
                    acc_in_d = acc_in;
                    result_d = '0;
                    carry_d  = 1'b0;
                    done_d   = 1'b0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (mul_last) state_d = S_ADD;
            end
            S_ADD: begin
                result_d = sum[ACC_W-1:0];
                carry_d  = sum[ACC_W];
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            acc_in_q <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_in_q <= acc_in_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign product = mul_prod;
    assign result  = result_q;
    assign carry   = carry_q;
    assign done    = done_q;
    assign busy    = (state_q == S_MUL) || (state_q == S_ADD);

endmodule

// File: tb/tb_seq_mul_add16.sv
// Self-checking bench for seq_mul_add16: vector table, hand sequences and random MACs.
module tb_seq_mul_add16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] acc_in;
    logic [15:0] product;
    logic        mul_done;
    logic [15:0] result;
    logic        carry;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  xv;
        logic [7:0]  yv;
        logic [15:0] av;
        logic [15:0] ep;
        logic [15:0] er;
        logic        ec;
    } vec_t;

    vec_t vecs[7];

    seq_mul_add16 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .y        (y),
        .acc_in   (acc_in),
        .product  (product),
        .mul_done (mul_done),
        .result   (result),
        .carry    (carry),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: full-precision unsigned MAC, split into low 16 bits and carry.
    function automatic logic [16:0] mac_model(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned s;
        s = a * b + c;
        return s[16:0];
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_product"},  32'(product),  0);
        chk({tag, "_mul_done"}, 32'(mul_done), 0);
        chk({tag, "_result"},   32'(result),   0);
        chk({tag, "_carry"},    32'(carry),    0);
        chk({tag, "_done"},     32'(done),     0);
        chk({tag, "_busy"},     32'(busy),     0);
    endtask

    // One MAC step. Operands are scrambled after E0; optionally start is re-pulsed mid-MUL.
    task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] av,
                          input logic [15:0] ep, input logic [15:0] er, input logic ec,
                          input bit pulse_mid);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        x = xv; y = yv; acc_in = av; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            x = 8'($urandom); y = 8'($urandom); acc_in = 16'($urandom);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k == 0) begin
                chk("e0_done_cleared",   32'(done),   0);
                chk("e0_result_cleared", 32'(result), 0);
                chk("e0_carry_cleared",  32'(carry),  0);
            end
            if (k < 8) chk("mul_done_early", 32'(mul_done), 0);
            if (k < 9) chk("done_early", 32'(done), 0);
            if (k == 8) begin
                chk("mul_done_e8", 32'(mul_done), 1);
                chk("product_e8",  32'(product),  32'(ep));
            end
            if (k == 9) begin
                chk("done_e9",   32'(done),   1);
                chk("result_e9", 32'(result), 32'(er));
                chk("carry_e9",  32'(carry),  32'(ec));
                chk("product_e9", 32'(product), 32'(ep));
                chk("busy_e9",   32'(busy),   0);
            end
            if (pulse_mid && k == 3) start = 1'b1;
        end
        chk("busy_cycles", 32'(busy_cnt), 9);
    endtask

    initial begin
        logic [7:0]  rx, ry;
        logic [15:0] ra;
        logic [16:0] m;

        vecs[0] = '{xv: 8'd5,   yv: 8'd2,   av: 16'd10,    ep: 16'd10,    er: 16'd20,    ec: 1'b0};
        vecs[1] = '{xv: 8'd255, yv: 8'd255, av: 16'd0,     ep: 16'd65025, er: 16'd65025, ec: 1'b0};
        vecs[2] = '{xv: 8'd255, yv: 8'd255, av: 16'd1000,  ep: 16'd65025, er: 16'd489,   ec: 1'b1};
        vecs[3] = '{xv: 8'd0,   yv: 8'd200, av: 16'd1234,  ep: 16'd0,     er: 16'd1234,  ec: 1'b0};
        vecs[4] = '{xv: 8'd1,   yv: 8'd1,   av: 16'd65535, ep: 16'd1,     er: 16'd0,     ec: 1'b1};
        vecs[5] = '{xv: 8'd128, yv: 8'd2,   av: 16'd65280, ep: 16'd256,   er: 16'd0,     ec: 1'b1};
        vecs[6] = '{xv: 8'd200, yv: 8'd0,   av: 16'd7,     ep: 16'd0,     er: 16'd7,     ec: 1'b0};

        reset = 1'b0; start = 1'b0; x = '0; y = '0; acc_in = '0;
        #22;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle");

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].xv, vecs[i].yv, vecs[i].av, vecs[i].ep, vecs[i].er, vecs[i].ec, 1'b0);

        // Results hold in DONE without start.
        repeat (4) @(negedge clk);
        chk("hold_done",    32'(done),    1);
        chk("hold_result",  32'(result),  7);
        chk("hold_product", 32'(product), 0);
        chk("hold_busy",    32'(busy),    0);

        // Start re-pulsed during MUL must not disturb the running operation.
        run_op(8'd5, 8'd2, 16'd10, 16'd10, 16'd20, 1'b0, 1'b1);
        @(negedge clk);
        chk("no_restart_done", 32'(done), 1);
        chk("no_restart_busy", 32'(busy), 0);

        // Reset mid-MUL clears outputs without a clock edge.
        @(negedge clk);
        x = 8'd77; y = 8'd99; acc_in = 16'd555; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("reset_held");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");
        run_op(8'd3, 8'd3, 16'd0, 16'd9, 16'd9, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            ra = 16'($urandom);
            if (i == 0) begin rx = 8'd255; ry = 8'd255; ra = 16'hFFFF; end
            m = mac_model(int'(rx), int'(ry), int'(ra));
            run_op(rx, ry, ra, 16'(int'(rx) * int'(ry)), m[15:0], m[16], ($urandom % 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
